cdb_arbiter: RTL

Shares the single common data bus (CDB) between the two result producers in the execute stage: the reservation-station ALU and the load/store buffer (LSB). Each producer writes into its own small FIFO, and a registered arbiter broadcasts at most one result per cycle to the RoB and to both issue queues. Producers are stalled through per-source back-pressure, and the whole block clears on pipeline flush.

---
 rtl/cdb_arbiter_pkg.sv | 12 +
 rtl/cdb_fifo.sv | 55 +++++
 rtl/cdb_arbiter.sv | 109 ++++++++++
 3 files changed

// File: rtl/cdb_arbiter_pkg.sv
// Shared constants and source encoding for the CDB arbiter slice.
package cdb_arbiter_pkg;

  localparam int unsigned CDB_DATA_WIDTH = 32;
  localparam int unsigned STALL_SLACK    = 2;

  typedef enum logic {
    SRC_ALU = 1'b0,
    SRC_LSB = 1'b1
  } cdb_src_e;

endpackage

// File: rtl/cdb_fifo.sv
// Per-source result FIFO; a push into a full FIFO is accepted only alongside a pop.
module cdb_fifo #(
  parameter int unsigned WIDTH = 36,
  parameter int unsigned AW    = 2,
  parameter int unsigned DEPTH = 1 << AW
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             flush,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] head,
  output logic [AW:0]      count,
  output logic             full,
  output logic             empty
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    wr_ptr;
  logic             do_push;
  logic             do_pop;

  function automatic logic [AW-1:0] next_ptr(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
  endfunction

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign head    = mem[rd_ptr];
  assign do_pop  = pop && !empty;
  assign do_push = push && !flush && (!full || do_pop);

  always_ff @(posedge clk_in) begin
    if (rst_in || flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= next_ptr(wr_ptr);
      if (do_pop)  rd_ptr <= next_ptr(rd_ptr);
      count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (do_push) begin
      mem[wr_ptr] <= din;
    end
  end

endmodule

// File: rtl/cdb_arbiter.sv
// Two-source CDB arbiter: per-source FIFOs, registered broadcast, stall decode.
// CDB_ARB_RR_EN selects round-robin; otherwise the LSB wins when both heads are valid.
module cdb_arbiter
  import cdb_arbiter_pkg::*;
#(
  parameter int unsigned RoB_WIDTH  = 4,
  parameter int unsigned FIFO_WIDTH = 2,
  parameter int unsigned FIFO_DEPTH = 1 << FIFO_WIDTH
) (
  input  logic                 clk_in,
  input  logic                 rst_in,
  input  logic                 rdy_in,
  input  logic                 flush_signal,
  input  logic                 alu_en,
  input  logic [RoB_WIDTH-1:0] alu_index,
  input  logic [31:0]          alu_data,
  input  logic                 lsb_en,
  input  logic [RoB_WIDTH-1:0] lsb_index,
  input  logic [31:0]          lsb_data,
  output logic                 alu_stall,
  output logic                 lsb_stall,
  output logic                 CDB_update_en,
  output logic [RoB_WIDTH-1:0] CDB_update_index,
  output logic [31:0]          CDB_update_data,
  output logic                 CDB_source,
  output logic                 overflow
);

  typedef struct packed {
    logic [RoB_WIDTH-1:0]      index;
    logic [CDB_DATA_WIDTH-1:0] data;
  } cdb_rec_t;

  localparam int unsigned REC_W = $bits(cdb_rec_t);

  cdb_rec_t        alu_head, lsb_head, grant_rec;
  logic [FIFO_WIDTH:0] alu_count, lsb_count;
  logic            alu_full, alu_empty, lsb_full, lsb_empty;
  logic            run, alu_push, lsb_push, alu_pop, lsb_pop, any_valid;
  cdb_src_e        grant_src;
`ifdef CDB_ARB_RR_EN
  cdb_src_e        last_grant;
`endif

  assign run      = rdy_in && !flush_signal;
  assign alu_push = run && alu_en;
  assign lsb_push = run && lsb_en;

  cdb_fifo #(.WIDTH(REC_W), .AW(FIFO_WIDTH), .DEPTH(FIFO_DEPTH)) u_alu_fifo (
    .clk_in(clk_in), .rst_in(rst_in), .flush(flush_signal),
    .push(alu_push), .pop(alu_pop), .din({alu_index, alu_data}),
    .head(alu_head), .count(alu_count), .full(alu_full), .empty(alu_empty)
  );

  cdb_fifo #(.WIDTH(REC_W), .AW(FIFO_WIDTH), .DEPTH(FIFO_DEPTH)) u_lsb_fifo (
    .clk_in(clk_in), .rst_in(rst_in), .flush(flush_signal),
    .push(lsb_push), .pop(lsb_pop), .din({lsb_index, lsb_data}),
    .head(lsb_head), .count(lsb_count), .full(lsb_full), .empty(lsb_empty)
  );

  always_comb begin
    any_valid = !alu_empty || !lsb_empty;
    grant_src = lsb_empty ? SRC_ALU : SRC_LSB;
`ifdef CDB_ARB_RR_EN
    if (!alu_empty && !lsb_empty)
      grant_src = (last_grant == SRC_ALU) ? SRC_LSB : SRC_ALU;
`endif
    grant_rec = (grant_src == SRC_LSB) ? lsb_head : alu_head;
    alu_pop   = run && !alu_empty && (grant_src == SRC_ALU);
    lsb_pop   = run && !lsb_empty && (grant_src == SRC_LSB);
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      CDB_update_en    <= 1'b0;
      CDB_update_index <= '0;
      CDB_update_data  <= '0;
      CDB_source       <= 1'b0;
    end else if (!run) begin
      CDB_update_en <= 1'b0;
    end else begin
      CDB_update_en <= any_valid;
      if (any_valid) begin
        CDB_update_index <= grant_rec.index;
        CDB_update_data  <= grant_rec.data;
        CDB_source       <= grant_src;
      end
    end
  end

`ifdef CDB_ARB_RR_EN
  // Cleared as "LSB went last" so the ALU wins the first contested cycle.
  always_ff @(posedge clk_in) begin
    if (rst_in || flush_signal) last_grant <= SRC_LSB;
    else if (run && any_valid)  last_grant <= grant_src;
  end
`endif

  always_ff @(posedge clk_in) begin
    if (rst_in)
      overflow <= 1'b0;
    else if ((alu_push && alu_full && !alu_pop) || (lsb_push && lsb_full && !lsb_pop))
      overflow <= 1'b1;
  end

  assign alu_stall = (alu_count >= (FIFO_WIDTH+1)'(FIFO_DEPTH - STALL_SLACK));
  assign lsb_stall = (lsb_count >= (FIFO_WIDTH+1)'(FIFO_DEPTH - STALL_SLACK));

endmodule
